vga_frame_reader: RTL
=====================

Name: vga_frame_reader

Overview:
Read-side counterpart to the character/pixel writers that fill the 640x480, 3-bit-per-pixel frame buffer. Generates 640x480@60 VGA scan timing and issues one linear read address per visible pixel to the frame buffer read port. Realigns sync and blank with the returned pixel data, then expands each 3-bit colour to 8-bit R/G/B. Sits between the frame buffer RAM read port and the VGA DAC pins.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (ticks)
H_SYNC, 96, horizontal sync width (ticks)
H_BP, 48, horizontal back porch (ticks)
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width (lines)
V_BP, 33, vertical back porch (lines)
READ_LATENCY, 1, frame buffer read latency in pixel ticks; legal range 1..3

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
pixel_en  in  1  pixel tick; all scan state advances only on cycles where this is 1
mem_raddr  out  19  frame buffer read address (linear pixel index)
mem_rdata  in  3  frame buffer read data; bit2=R, bit1=G, bit0=B
vga_r  out  8  red
vga_g  out  8  green
vga_b  out  8  blue
vga_hs  out  1  horizontal sync, active low
vga_vs  out  1  vertical sync, active low
vga_blank_n  out  1  1 = visible pixel on the outputs
frame_start  out  1  one-clock pulse at frame wrap
h_count_out  out  10  current horizontal counter (debug)
v_count_out  out  10  current vertical counter (debug)

Behaviour:
- Reset is synchronous and active-high. Reset values:
  - h=0, v=0, mem_raddr=0, frame_start=0.
  - vga_r/g/b=0, vga_hs=1, vga_vs=1, vga_blank_n=0.
  - Alignment pipeline cleared to the blank state.
  - Reset asserted mid-frame takes effect on the next clock edge regardless of pixel_en.
- Counters:
  - h counts 0..H_TOTAL-1, where H_TOTAL = sum of the four H parameters = 800.
  - v counts 0..V_TOTAL-1, where V_TOTAL = 525.
  - On each pixel_en: h increments. At H_TOTAL-1, h wraps to 0 and v increments. At (H_TOTAL-1, V_TOTAL-1), both wrap to 0.
  - pixel_en=0: all state and all outputs hold unchanged, except frame_start, which is forced to 0.
- Active region: h<H_ACTIVE and v<V_ACTIVE.
- Raw sync timing (before alignment delay):
  - hs_raw = 0 for H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC, i.e. 656..751.
  - vs_raw = 0 for V_ACTIVE+V_FP <= v < V_ACTIVE+V_FP+V_SYNC, i.e. 490..491.
- Address generation:
  - Incremental; no multiplier.
  - mem_raddr always presents the address of the pixel at the current (h,v) when that pixel is active. This equals v*640+h.
  - mem_raddr increments by 1 on each pixel_en tick that leaves an active pixel.
  - mem_raddr holds its value through blanking.
  - mem_raddr resets to 0 on the frame wrap.
  - Maximum address is 307199; it never exceeds this.
  - mem_raddr is stable between ticks, so a RAM with 1-clock latency satisfies READ_LATENCY=1 whenever pixel_en spacing is at least 2 clocks.
- Alignment:
  - active, hs_raw and vs_raw pass through a READ_LATENCY-deep shift register that advances on pixel_en.
  - mem_rdata is sampled on the pixel_en tick on which the delayed active bit emerges.
  - Result: vga_* outputs change exactly READ_LATENCY+1 ticks after the (h,v) they describe, and all change together.
- Colour:
  - Each channel = 8'hFF if its data bit is 1, otherwise 8'h00.
  - All channels = 0 when delayed active = 0.
  - vga_blank_n = delayed active.
- frame_start: asserted for one clock on the pixel_en cycle at which the counters wrap from (799,524) to (0,0). Not asserted on the first tick after reset.

Test Plan:
- Reset: hold reset 3 cycles with pixel_en=1 -> all outputs at the reset values above; h_count_out=0 and v_count_out=0 one cycle after reset deasserts.
- Address sequence: pixel_en=1 every clock, with a RAM model that returns addr[2:0] after 1 tick.
  - mem_raddr reads 0..639 on line 0, holds 639 through h=640..799, then 640 at h=0 of line 1.
  - mem_raddr is 307199 at (639,479) and 0 after the wrap.
- Data alignment: with the same RAM model, vga_blank_n first rises 2 ticks after reset release with R/G/B=00/00/00. The next pixel (addr 1, colour 3'b001) gives vga_b=FF and vga_r=vga_g=00. Repeat with READ_LATENCY=3: first visible pixel appears 4 ticks after reset release.
- Sync timing:
  - vga_hs is low for exactly 96 ticks per line, starting 656+READ_LATENCY+1 ticks after h=0.
  - vga_vs is low for exactly 2×800 ticks per frame.
  - frame_start pulses once every 420000 ticks.
- pixel_en gating: toggle pixel_en every other clock -> outputs are identical to the continuous run when sampled on enable cycles; frame_start is never high when pixel_en=0.
- Mid-frame reset: assert reset at (h=300, v=200) -> next cycle h=v=0, mem_raddr=0, blank_n=0; the subsequent frame is identical to the first frame after power-up.

Source files
------------

// File: rtl/vga_frame_reader_if.sv
// Bundle between the VGA frame reader, its frame buffer read port and the DAC pins.
// master is the reader; slave is the RAM/DAC side that supplies the tick and read data.
interface vga_frame_reader_if;
    logic        pixel_en;
    logic [18:0] mem_raddr;
    logic [2:0]  mem_rdata;
    logic [7:0]  vga_r;
    logic [7:0]  vga_g;
    logic [7:0]  vga_b;
    logic        vga_hs;
    logic        vga_vs;
    logic        vga_blank_n;
    logic        frame_start;
    logic [9:0]  h_count_out;
    logic [9:0]  v_count_out;

    modport master (
        input  pixel_en, mem_rdata,
        output mem_raddr, vga_r, vga_g, vga_b, vga_hs, vga_vs, vga_blank_n,
               frame_start, h_count_out, v_count_out
    );

    modport slave (
        output pixel_en, mem_rdata,
        input  mem_raddr, vga_r, vga_g, vga_b, vga_hs, vga_vs, vga_blank_n,
               frame_start, h_count_out, v_count_out
    );
endinterface

// File: rtl/vga_frame_reader.sv
// 640x480@60 scan generator that reads a 3-bit frame buffer linearly and drives the VGA DAC.
// Sync/blank travel through a pipeline matched to the RAM latency so they leave with the pixel.
module vga_frame_reader #(
    parameter int H_ACTIVE     = 640,
    parameter int H_FP         = 16,
    parameter int H_SYNC       = 96,
    parameter int H_BP         = 48,
    parameter int V_ACTIVE     = 480,
    parameter int V_FP         = 10,
    parameter int V_SYNC       = 2,
    parameter int V_BP         = 33,
    parameter int READ_LATENCY = 1
) (
    input  logic               clock,
    input  logic               reset,
    vga_frame_reader_if.master bus
);
    localparam logic [9:0] H_LAST     = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [9:0] V_LAST     = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
    localparam logic [9:0] H_VIS      = 10'(H_ACTIVE);
    localparam logic [9:0] H_VIS_LAST = 10'(H_ACTIVE - 1);
    localparam logic [9:0] V_VIS      = 10'(V_ACTIVE);
    localparam logic [9:0] V_VIS_LAST = 10'(V_ACTIVE - 1);
    localparam logic [9:0] HS_BEG     = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_END     = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] VS_BEG     = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_END     = 10'(V_ACTIVE + V_FP + V_SYNC);

    logic [9:0]              r_h;
    logic [9:0]              r_v;
    logic [18:0]             r_addr;
    logic [READ_LATENCY:0]   r_act_p;
    logic [READ_LATENCY:0]   r_hs_p;
    logic [READ_LATENCY:0]   r_vs_p;
    logic [7:0]              r_r;
    logic [7:0]              r_g;
    logic [7:0]              r_b;

    logic w_h_last;
    logic w_v_last;
    logic w_active;
    logic w_hs_raw;
    logic w_vs_raw;
    logic w_addr_inc;
    logic w_act_dly;

    function automatic logic [7:0] expand_channel(input logic bit_v, input logic visible);
        return (bit_v && visible) ? 8'hFF : 8'h00;
    endfunction

    assign w_h_last = (r_h == H_LAST);
    assign w_v_last = (r_v == V_LAST);
    assign w_active = (r_h < H_VIS) && (r_v < V_VIS);
    assign w_hs_raw = !((r_h >= HS_BEG) && (r_h < HS_END));
    assign w_vs_raw = !((r_v >= VS_BEG) && (r_v < VS_END));

    // Step to the next pixel only when it is visible: either the next column on this line,
    // or the first column of the next visible line. Otherwise the last address is held.
    assign w_addr_inc = (w_active && (r_h != H_VIS_LAST)) || (w_h_last && (r_v < V_VIS_LAST));

    // Bit READ_LATENCY-1 lines up with the returning RAM data; the top bit is the output stage.
    assign w_act_dly = r_act_p[READ_LATENCY-1];

    always_ff @(posedge clock) begin
        if (reset) begin
            r_h     <= '0;
            r_v     <= '0;
            r_addr  <= '0;
            r_act_p <= '0;
            r_hs_p  <= '1;
            r_vs_p  <= '1;
            r_r     <= 8'h00;
            r_g     <= 8'h00;
            r_b     <= 8'h00;
        end else if (bus.pixel_en) begin
            if (w_h_last) begin
                r_h <= '0;
                r_v <= w_v_last ? 10'd0 : r_v + 10'd1;
            end else begin
                r_h <= r_h + 10'd1;
            end

            if (w_h_last && w_v_last) begin
                r_addr <= '0;
            end else if (w_addr_inc) begin
                r_addr <= r_addr + 19'd1;
            end

            r_act_p <= {r_act_p[READ_LATENCY-1:0], w_active};
            r_hs_p  <= {r_hs_p[READ_LATENCY-1:0], w_hs_raw};
            r_vs_p  <= {r_vs_p[READ_LATENCY-1:0], w_vs_raw};

            r_r <= expand_channel(bus.mem_rdata[2], w_act_dly);
            r_g <= expand_channel(bus.mem_rdata[1], w_act_dly);
            r_b <= expand_channel(bus.mem_rdata[0], w_act_dly);
        end
    end

    assign bus.mem_raddr   = r_addr;
    assign bus.vga_r       = r_r;
    assign bus.vga_g       = r_g;
    assign bus.vga_b       = r_b;
    assign bus.vga_hs      = r_hs_p[READ_LATENCY];
    assign bus.vga_vs      = r_vs_p[READ_LATENCY];
    assign bus.vga_blank_n = r_act_p[READ_LATENCY];
    assign bus.h_count_out = r_h;
    assign bus.v_count_out = r_v;

    // Qualified by the tick itself so it can never be seen while pixel_en is low.
    assign bus.frame_start = bus.pixel_en && !reset && w_h_last && w_v_last;
endmodule
